pipelined_control_unit: RTL and testbench

//  Registered successor to the combinational decoder: decodes {opcode,func} into control plus

---
 rtl/pipelined_control_unit.sv | 183 ++++++++++++++++++
 tb/tb_pipelined_control_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_control_unit.sv
// ID/EX pipeline register with decode of {opcode,func}, valid/ready flow control,
// flush, and load-use bubble insertion.
module pipelined_control_unit #(
  parameter int unsigned INSTR_W          = 32,
  parameter int unsigned REG_ADDR_W       = 5,
  parameter int unsigned ALUOP_W          = 3,
  parameter int unsigned LOAD_USE_BUBBLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTR_W-1:0]    instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ALUOP_W-1:0]    out_aluop,
  output logic                  out_regwrite,
  output logic                  out_branch,
  output logic                  out_bne,
  output logic                  out_jump,
  output logic                  out_jal,
  output logic                  out_jr,
  output logic                  out_memread,
  output logic                  out_memwrite,
  output logic                  out_byte,
  output logic                  out_lui,
  output logic                  out_illegal,
  output logic [REG_ADDR_W-1:0] out_dest,
  output logic [REG_ADDR_W-1:0] out_rs,
  output logic [REG_ADDR_W-1:0] out_rt
);

  typedef enum logic {IDLE, STALL} state_t;

  typedef struct packed {
    logic [ALUOP_W-1:0]    aluop;
    logic                  regwrite;
    logic                  branch;
    logic                  bne;
    logic                  jump;
    logic                  jal;
    logic                  jr;
    logic                  memread;
    logic                  memwrite;
    logic                  mem_byte;
    logic                  lui;
    logic                  illegal;
    logic [REG_ADDR_W-1:0] dest;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
  } entry_t;

  localparam logic [2:0] STALL_CNT = 3'(LOAD_USE_BUBBLES - 1);

  logic [5:0]            f_op, f_func;
  logic [REG_ADDR_W-1:0] f_rs, f_rt, f_rd;
  logic                  unused_shamt;

  assign f_op         = instr[31:26];
  assign f_func       = instr[5:0];
  assign f_rs         = REG_ADDR_W'(instr[25:21]);
  assign f_rt         = REG_ADDR_W'(instr[20:16]);
  assign f_rd         = REG_ADDR_W'(instr[15:11]);
  assign unused_shamt = ^instr[10:6];

  entry_t dec;

  always_comb begin
    dec    = '0;
    dec.rs = f_rs;
    dec.rt = f_rt;
    case (f_op)
      6'h03: begin
        case (f_func)
          6'h08: begin dec.jump = 1'b1; dec.jr = 1'b1; end
          6'h21: begin dec.regwrite = 1'b1; dec.memread = 1'b1; end
          6'h13: dec.memwrite = 1'b1;
          default: dec.regwrite = 1'b1;
        endcase
        if (dec.regwrite) dec.dest = f_rd;
      end
      6'h02: dec.jump = 1'b1;
      6'h07: begin dec.jump = 1'b1; dec.jal = 1'b1; dec.regwrite = 1'b1; dec.dest = '1; end
      6'h09: begin dec.aluop = ALUOP_W'(1); dec.regwrite = 1'b1; dec.dest = f_rt; end
      6'h0c: begin dec.aluop = ALUOP_W'(3); dec.regwrite = 1'b1; dec.dest = f_rt; end
      6'h0e: begin dec.aluop = ALUOP_W'(4); dec.regwrite = 1'b1; dec.dest = f_rt; end
      6'h04: begin dec.aluop = ALUOP_W'(2); dec.branch = 1'b1; end
      6'h05: begin dec.aluop = ALUOP_W'(2); dec.branch = 1'b1; dec.bne = 1'b1; end
      6'h0f: begin dec.lui = 1'b1; dec.regwrite = 1'b1; dec.dest = f_rt; end
      6'h12: begin
        dec.aluop = ALUOP_W'(1); dec.memread = 1'b1; dec.regwrite = 1'b1; dec.dest = f_rt;
      end
      6'h22: begin
        dec.aluop = ALUOP_W'(1); dec.memread = 1'b1; dec.mem_byte = 1'b1;
        dec.regwrite = 1'b1; dec.dest = f_rt;
      end
      6'h28: begin dec.aluop = ALUOP_W'(1); dec.memwrite = 1'b1; dec.mem_byte = 1'b1; end
      6'h2b: begin dec.aluop = ALUOP_W'(1); dec.memwrite = 1'b1; end
      default: dec.illegal = 1'b1;
    endcase
  end

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       valid_q, valid_d;
  entry_t     entry_q, entry_d;
  logic       adv, hazard;

  assign adv    = !valid_q || out_ready;
  // Load in ID/EX whose destination is read by the instruction now on the input.
  assign hazard = valid_q && entry_q.memread && (entry_q.dest != '0) &&
                  ((entry_q.dest == f_rs) || (entry_q.dest == f_rt));
  assign in_ready = rst_n && !flush && adv && (state_q == IDLE) && !hazard;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    entry_d = entry_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
      entry_d = '0;
    end else if (adv) begin
      case (state_q)
        IDLE: begin
          if (in_valid && !hazard) begin
            valid_d = 1'b1;
            entry_d = dec;
          end else begin
            valid_d = 1'b0;
            entry_d = '0;
            if (in_valid && (LOAD_USE_BUBBLES > 1)) begin
              state_d = STALL;
              cnt_d   = STALL_CNT;
            end
          end
        end
        STALL: begin
          valid_d = 1'b0;
          entry_d = '0;
          cnt_d   = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_aluop    = entry_q.aluop;
  assign out_regwrite = entry_q.regwrite;
  assign out_branch   = entry_q.branch;
  assign out_bne      = entry_q.bne;
  assign out_jump     = entry_q.jump;
  assign out_jal      = entry_q.jal;
  assign out_jr       = entry_q.jr;
  assign out_memread  = entry_q.memread;
  assign out_memwrite = entry_q.memwrite;
  assign out_byte     = entry_q.mem_byte;
  assign out_lui      = entry_q.lui;
  assign out_illegal  = entry_q.illegal;
  assign out_dest     = entry_q.dest;
  assign out_rs       = entry_q.rs;
  assign out_rt       = entry_q.rt;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: two instances (1 and 3 load-use bubbles) share stimulus
// and are compared every cycle against a behavioural decode/flow model.
module tb_pipelined_control_unit;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] instr;

  logic [1:0] in_ready, out_valid, regwrite, branch, bne, jump, jal, jr;
  logic [1:0] memread, memwrite, mbyte, lui, illegal;
  logic [2:0] aluop [2];
  logic [4:0] dest [2], rs [2], rt [2];
  logic [28:0] dv [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pipelined_control_unit #(.INSTR_W(32), .REG_ADDR_W(5), .ALUOP_W(3),
                             .LOAD_USE_BUBBLES(g == 0 ? 1 : 3)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[g]),
      .instr(instr), .out_valid(out_valid[g]), .out_ready(out_ready),
      .out_aluop(aluop[g]), .out_regwrite(regwrite[g]), .out_branch(branch[g]),
      .out_bne(bne[g]), .out_jump(jump[g]), .out_jal(jal[g]), .out_jr(jr[g]),
      .out_memread(memread[g]), .out_memwrite(memwrite[g]), .out_byte(mbyte[g]),
      .out_lui(lui[g]), .out_illegal(illegal[g]), .out_dest(dest[g]), .out_rs(rs[g]),
      .out_rt(rt[g])
    );
    assign dv[g] = {aluop[g], regwrite[g], branch[g], bne[g], jump[g], jal[g], jr[g],
                    memread[g], memwrite[g], mbyte[g], lui[g], illegal[g],
                    dest[g], rs[g], rt[g]};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Layout {aluop[28:26], wr, br, bne, jump, jal, jr, mrd, mwr, byte, lui, ill, dest, rs, rt}.
  function automatic bit [28:0] ref_decode(input bit [31:0] ins);
    bit [5:0] op, fn;
    bit [4:0] i_rs, i_rt, i_rd, d;
    bit [2:0] a;
    bit rt_, known, wr, br, bn, jp, jl, jrr, mr, mw, by, lu;
    op = ins[31:26]; fn = ins[5:0];
    i_rs = ins[25:21]; i_rt = ins[20:16]; i_rd = ins[15:11];
    rt_   = (op == 6'h03);
    known = op inside {6'h03, 6'h02, 6'h07, 6'h09, 6'h0c, 6'h04, 6'h05,
                       6'h22, 6'h0f, 6'h12, 6'h0e, 6'h28, 6'h2b};
    if (!known) return {3'd0, 10'd0, 1'b1, 5'd0, i_rs, i_rt};
    a   = (op inside {6'h09, 6'h22, 6'h12, 6'h28, 6'h2b}) ? 3'd1 :
          (op == 6'h0c) ? 3'd3 : (op inside {6'h04, 6'h05}) ? 3'd2 :
          (op == 6'h0e) ? 3'd4 : 3'd0;
    wr  = (rt_ && !(fn inside {6'h08, 6'h13})) ||
          (op inside {6'h07, 6'h09, 6'h0c, 6'h22, 6'h0f, 6'h12, 6'h0e});
    br  = op inside {6'h04, 6'h05};
    bn  = (op == 6'h05);
    jrr = rt_ && (fn == 6'h08);
    jl  = (op == 6'h07);
    jp  = (op == 6'h02) || jl || jrr;
    mr  = (op inside {6'h22, 6'h12}) || (rt_ && fn == 6'h21);
    mw  = (op inside {6'h28, 6'h2b}) || (rt_ && fn == 6'h13);
    by  = op inside {6'h22, 6'h28};
    lu  = (op == 6'h0f);
    d   = !wr ? 5'd0 : jl ? 5'd31 : rt_ ? i_rd : i_rt;
    return {a, wr, br, bn, jp, jl, jrr, mr, mw, by, lu, 1'b0, d, i_rs, i_rt};
  endfunction

  // Model state per instance: held entry plus pending extra bubbles.
  bit        m_v [2];
  bit [28:0] m_e [2];
  int        m_stall [2];
  int        lub [2] = '{1, 3};

  initial begin
    forever begin
      bit hz, adv, exp_rdy;
      @(negedge clk);
      #4;
      for (int g = 0; g < 2; g++) begin
        hz = m_v[g] && m_e[g][19] && (m_e[g][14:10] != 5'd0) &&
             (m_e[g][14:10] == instr[25:21] || m_e[g][14:10] == instr[20:16]);
        adv = !m_v[g] || out_ready;
        exp_rdy = rst_n && !flush && adv && (m_stall[g] == 0) && !hz;
        chk($sformatf("valid%0d", g), out_valid[g], m_v[g]);
        chk($sformatf("entry%0d", g), dv[g], m_e[g]);
        chk($sformatf("in_ready%0d", g), in_ready[g], exp_rdy);
        if (!rst_n || flush) begin
          m_v[g] = 0; m_e[g] = '0; m_stall[g] = 0;
        end else if (adv) begin
          if (m_stall[g] > 0) begin
            m_v[g] = 0; m_e[g] = '0; m_stall[g]--;
          end else if (in_valid && hz) begin
            m_v[g] = 0; m_e[g] = '0; m_stall[g] = lub[g] - 1;
          end else if (in_valid) begin
            m_v[g] = 1; m_e[g] = ref_decode(instr);
          end else begin
            m_v[g] = 0; m_e[g] = '0;
          end
        end
      end
    end
  end

  task automatic drv(input bit v, input bit [31:0] ins, input bit ordy, input bit fl);
    @(negedge clk);
    in_valid = v; instr = ins; out_ready = ordy; flush = fl;
  endtask

  function automatic bit [31:0] rand_instr();
    bit [5:0] ops [15];
    bit [5:0] fns [5];
    bit [5:0] op, fn;
    ops = '{6'h03, 6'h03, 6'h03, 6'h02, 6'h07, 6'h09, 6'h0c, 6'h04,
            6'h05, 6'h22, 6'h0f, 6'h12, 6'h0e, 6'h28, 6'h2b};
    fns = '{6'h08, 6'h21, 6'h13, 6'h20, 6'h22};
    op = ($urandom_range(15) == 0) ? 6'($urandom) : ops[$urandom_range(14)];
    fn = fns[$urandom_range(4)];
    return {op, 5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
            5'($urandom), fn};
  endfunction

  localparam logic [31:0] ADDI = 32'h2528000A;
  localparam logic [31:0] JAL  = {6'h07, 26'h0};
  localparam logic [31:0] ILL  = {6'h3F, 26'h0};
  localparam logic [31:0] ORI  = {6'h0e, 5'd2, 5'd3, 16'h0001};
  localparam logic [31:0] LW5  = {6'h12, 5'd1, 5'd5, 16'h0};
  localparam logic [31:0] ADD  = {6'h03, 5'd5, 5'd7, 5'd6, 5'd0, 6'h20};
  localparam logic [31:0] LW0  = {6'h12, 5'd1, 5'd0, 16'h0};
  localparam logic [31:0] ADD0 = {6'h03, 5'd0, 5'd7, 5'd6, 5'd0, 6'h20};

  initial begin
    int  nb [2];
    bit  seen [2];
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 1; instr = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_valid", out_valid[0], 0);
    chk("rst_ready", in_ready[0], 0);
    chk("rst_ctrl", dv[0], 0);
    rst_n = 1; #1;
    chk("rel_ready", in_ready[0], 1);

    drv(1, ADDI, 1, 0); drv(0, '0, 1, 0);
    chk("addi_valid", out_valid[0], 1);
    chk("addi_aluop", aluop[0], 1);
    chk("addi_wr", regwrite[0], 1);
    chk("addi_dest", dest[0], 8);
    drv(1, JAL, 1, 0); drv(0, '0, 1, 0);
    chk("jal_jal", jal[0], 1);
    chk("jal_dest", dest[0], 31);
    drv(1, ILL, 1, 0); drv(0, '0, 1, 0);
    chk("ill_flag", illegal[0], 1);
    chk("ill_wr", regwrite[0], 0);

    drv(1, LW5, 1, 0); drv(1, ADD, 1, 0); #1;
    chk("lu_ready0", in_ready[0], 0);
    chk("lu_ready1", in_ready[1], 0);
    nb = '{0, 0}; seen = '{0, 0};
    for (int k = 0; k < 12 && !(seen[0] && seen[1]); k++) begin
      drv(1, ADD, 1, 0);
      for (int g = 0; g < 2; g++) begin
        if (!seen[g]) begin
          if (out_valid[g]) begin
            seen[g] = 1;
            chk($sformatf("lu_dest%0d", g), dest[g], 6);
          end else nb[g]++;
        end
      end
    end
    chk("bubbles_lub1", nb[0], 1);
    chk("bubbles_lub3", nb[1], 3);
    repeat (3) drv(0, '0, 1, 0);
    drv(1, LW0, 1, 0); drv(1, ADD0, 1, 0); #1;
    chk("lw0_ready0", in_ready[0], 1);
    chk("lw0_ready1", in_ready[1], 1);
    drv(0, '0, 1, 0);
    chk("lw0_dest", dest[0], 6);

    drv(1, ADDI, 1, 0);
    for (int k = 0; k < 4; k++) begin
      drv(1, ORI, 0, 0); #1;
      chk("bp_ready", in_ready[0], 0);
      chk("bp_hold", aluop[0], 1);
    end
    drv(1, ORI, 1, 0); #1;
    chk("bp_rel_ready", in_ready[0], 1);
    drv(0, '0, 1, 0);
    chk("bp_next", aluop[0], 4);
    chk("bp_next_dest", dest[0], 3);

    drv(1, ADDI, 1, 0); drv(1, ORI, 1, 1); #1;
    chk("fl_ready", in_ready[0], 0);
    drv(0, '0, 1, 0);
    chk("fl_valid", out_valid[0], 0);
    drv(1, LW5, 1, 0); drv(1, ADD, 1, 0); drv(1, ADD, 1, 1); drv(1, ADD, 1, 0); #1;
    chk("fl_stall_valid", out_valid[1], 0);
    chk("fl_stall_ready", in_ready[1], 1);
    drv(1, ADDI, 1, 0); drv(1, ORI, 0, 1); drv(0, '0, 0, 0);
    chk("fl_bp_valid", out_valid[0], 0);

    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      rst_n     = ($urandom_range(199) != 0);
      flush     = ($urandom_range(19) == 0);
      out_ready = ($urandom_range(3) != 0);
      in_valid  = ($urandom_range(3) != 0);
      instr     = rand_instr();
    end
    drv(0, '0, 1, 0); rst_n = 1;
    drv(0, '0, 1, 0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
